// File: rtl/strobe_fifo.sv
// Strobe-in / strobe-out word FIFO; 1-cycle latency from acceptance to strobe_out when empty.
// Backpressure: ready_in gates the head (PULSE=0) or strobes free-run (PULSE=1); strobe_in while full and not popping is dropped and flagged.
module strobe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PULSE = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       strobe_in,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       ready_in,
  output logic                       strobe_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clear_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             pulse_mode;
  logic             pop;
  logic             push;

  assign pulse_mode = (PULSE != 0);

  // All outputs come from registered state; ready_in/strobe_in only steer the next edge.
  assign strobe_out = (cnt != '0);
  assign full       = (cnt == FULL_CNT);
  assign count      = cnt;
  assign overflow   = ovf;
  assign data_out   = mem[rd_ptr];

  assign pop  = strobe_out & (ready_in | pulse_mode);
  assign push = strobe_in & (~full | pop);

  // When full with push and pop together, wr_ptr equals rd_ptr: the head is read out
  // combinationally this cycle and overwritten at the same edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A drop at the same edge as a clear wins, so no lost word goes unreported.
      if (strobe_in && !push) begin
        ovf <= 1'b1;
      end else if (clear_overflow) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/strobe_fifo.md
STROBE_FIFO -- requirements
Module: strobe_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: buffer capacity in words; power of two, >= 2.
REQ-003 SHALL have parameter PULSE, default 0: 0 = ready-gated output, 1 = free-running one-cycle strobes with ready_in ignored.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on posedge clk.
REQ-005 SHALL have port reset_n  input  1: synchronous, active-low reset, sampled on posedge clk.
REQ-006 SHALL have port strobe_in  input  1: offers data_in for capture this cycle.
REQ-007 SHALL have port data_in  input  WIDTH: word captured when strobe_in is accepted.
REQ-008 SHALL have port ready_in  input  1: consumer accepts the head word (PULSE=0 only).
REQ-009 SHALL have port strobe_out  output  1: data_out holds a valid head word.
REQ-010 SHALL have port data_out  output  WIDTH: head word; undefined content when strobe_out=0.
REQ-011 SHALL have port count  output  $clog2(DEPTH+1): words currently held.
REQ-012 SHALL have port full  output  1: count == DEPTH.
REQ-013 SHALL have port overflow  output  1: sticky flag, a strobe_in was dropped.
REQ-014 SHALL have port clear_overflow  input  1: clears overflow.

Function
REQ-015 SHALL implement FIFO ordering: words leave in exactly acceptance order, no duplication.
REQ-016 SHALL define pop = strobe_out & (ready_in | PULSE).
REQ-017 SHALL define push = strobe_in & (!full | pop); a word is accepted at the same posedge.
REQ-018 SHALL present an accepted word on strobe_out/data_out in the cycle after its acceptance edge when the FIFO was empty (1-cycle latency), otherwise once it becomes head.
REQ-019 SHALL keep strobe_out and data_out stable while strobe_out=1 and pop=0.
REQ-020 SHALL update count by +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-021 SHALL wrap read and write pointers modulo DEPTH with no gap or lost slot at wrap.
REQ-022 SHALL, when full and push and pop coincide, accept the new word and release the head; count stays DEPTH.
REQ-023 SHALL, when empty, never pop; a push while empty raises count to 1.
REQ-024 SHALL, on strobe_in while full and pop=0, drop data_in, leave contents and count unchanged, and set overflow at that edge.
REQ-025 SHALL clear overflow on clear_overflow=1; if a drop coincides with clear_overflow, overflow SHALL end set.
REQ-026 SHALL, with PULSE=1, pop the head every cycle strobe_out=1, giving one single-cycle strobe per word, back-to-back when words are queued.
REQ-027 SHALL derive full and strobe_out from registered state only; no combinational path from ready_in or strobe_in to any output.

Reset
REQ-028 SHALL, at a posedge with reset_n=0, zero pointers and count, clear overflow and discard all contents, overriding strobe_in, ready_in and clear_overflow.
REQ-029 SHALL hold strobe_out=0, full=0, count=0, overflow=0 in the cycle after reset, including reset mid-operation with a full buffer.
REQ-030 SHALL accept a strobe_in at the first posedge with reset_n=1.

Verification
REQ-031 SHALL cover latency: PULSE=0, ready_in=0, empty, strobe_in with data_in=0xA5 at edge k -> strobe_out=1, data_out=0xA5, count=1 after edge k; held until ready_in=1.
REQ-032 SHALL cover fill/overflow: DEPTH=4, ready_in=0, push 0x01..0x05 on consecutive edges -> full=1 after 4th, 0x05 dropped, overflow=1, count=4; drain gives 0x01..0x04.
REQ-033 SHALL cover full with simultaneous push/pop: full with 0x01..0x04, strobe_in=0x10 and ready_in=1 on one edge -> count=4; drain gives 0x02,0x03,0x04,0x10.
REQ-034 SHALL cover wrap: 10 rounds of push 3 and pop 3 words, random data -> output matches input order exactly; count returns to 0.
REQ-035 SHALL cover PULSE=1: push 0x11,0x22,0x33 on consecutive edges -> strobe_out high 3 consecutive cycles carrying 0x11,0x22,0x33, then low.
REQ-036 SHALL cover reset mid-operation: full, overflow=1, reset_n=0 for one edge with strobe_in=1 -> count=0, strobe_out=0, full=0, overflow=0; the next push is the only word output.
